// File: rtl/cpu_pipe_ctrl_pkg.sv
// ============================================================================
// cpu_pipe_pkg : shared types for the five-stage pipeline hazard controller
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package cpu_pipe_pkg;

  localparam int REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  rd_write;
    logic                  is_load;
  } stage_rec_t;

  // EX additionally remembers which sources its instruction reads
  typedef struct packed {
    stage_rec_t            base;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  rs1_used;
    logic                  rs2_used;
  } ex_rec_t;

endpackage

`default_nettype wire

// File: rtl/cpu_pipe_ctrl_fwd_unit.sv
// ============================================================================
// fwd_unit : per-operand EX forwarding select (EX/MEM beats MEM/WB)
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module fwd_unit
  import cpu_pipe_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] rs,
  input  logic                  rs_used,
  input  stage_rec_t            mem_rec,
  input  stage_rec_t            wb_rec,
  output fwd_sel_t              sel
);

  // A load in WB has its data, so the load flag only matters for MEM
  logic unused_wb_load;
  assign unused_wb_load = wb_rec.is_load;

  always_comb begin
    sel = FWD_RF;
    if (rs_used && mem_rec.valid && mem_rec.rd_write && !mem_rec.is_load &&
        (mem_rec.rd == rs)) begin
      sel = FWD_EXMEM;
    end else if (rs_used && wb_rec.valid && wb_rec.rd_write && (wb_rec.rd == rs)) begin
      sel = FWD_MEMWB;
    end
  end

endmodule

`default_nettype wire

// File: rtl/cpu_pipe_ctrl.sv
// ============================================================================
// cpu_pipe_ctrl : hazard/sequencing controller driving all pipeline enables
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module cpu_pipe_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int DSize    = 32,
  parameter int RegAddrW = REG_ADDR_W,
  parameter int CntW     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                CPU_STALL,
  input  logic                id_valid,
  input  logic [RegAddrW-1:0] id_rs1,
  input  logic [RegAddrW-1:0] id_rs2,
  input  logic                id_rs1_used,
  input  logic                id_rs2_used,
  input  logic [RegAddrW-1:0] id_rd,
  input  logic                id_rd_write,
  input  logic                id_is_load,
  input  logic                ex_branch_taken,
  input  logic                mem_wait,
  output logic                pc_enable,
  output logic                if_id_enable,
  output logic                id_ex_enable,
  output logic                ex_mem_enable,
  output logic                mem_wb_enable,
  output logic                if_id_flush,
  output logic                id_ex_bubble,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic [RegAddrW-1:0] wb_rd,
  output logic                wb_write,
  output logic [CntW-1:0]     stall_cycles,
  output logic [CntW-1:0]     flush_cycles
);

  if ((CntW > DSize) || (CntW < 16) || (RegAddrW != REG_ADDR_W)) begin : g_param_check
    $error("cpu_pipe_ctrl: unsupported CntW/DSize/RegAddrW combination");
  end

  localparam logic [CntW-1:0] CNT_ONE = {{(CntW-1){1'b0}}, 1'b1};

  ex_rec_t         ex_q, ex_d;
  stage_rec_t      mem_q, mem_d, wb_q, wb_d;
  logic            mwb_prev_q, mwb_prev_d;
  logic [CntW-1:0] stall_q, stall_d, flush_q, flush_d;
  logic            frozen, branch, load_use, rs1_hit, rs2_hit;

  always_comb begin
    frozen   = CPU_STALL | mem_wait;
    branch   = ex_branch_taken & ex_q.base.valid;
    rs1_hit  = id_rs1_used & (id_rs1 == ex_q.base.rd);
    rs2_hit  = id_rs2_used & (id_rs2 == ex_q.base.rd);
    load_use = ex_q.base.valid & ex_q.base.is_load & ex_q.base.rd_write &
               id_valid & (rs1_hit | rs2_hit);

    pc_enable     = 1'b0;
    if_id_enable  = 1'b0;
    id_ex_enable  = 1'b0;
    ex_mem_enable = 1'b0;
    mem_wb_enable = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    stall_d       = stall_q;
    flush_d       = flush_q;

    // While rst is low every control output stays quiet
    if (rst) begin
      if (frozen) begin
        if (stall_q != '1) stall_d = stall_q + CNT_ONE;
      end else if (branch) begin
        pc_enable     = 1'b1;
        if_id_enable  = 1'b1;
        id_ex_enable  = 1'b1;
        ex_mem_enable = 1'b1;
        mem_wb_enable = 1'b1;
        if_id_flush   = 1'b1;
        id_ex_bubble  = 1'b1;
        if (flush_q != '1) flush_d = flush_q + CNT_ONE;
      end else if (load_use) begin
        id_ex_enable  = 1'b1;
        ex_mem_enable = 1'b1;
        mem_wb_enable = 1'b1;
        id_ex_bubble  = 1'b1;
        if (stall_q != '1) stall_d = stall_q + CNT_ONE;
      end else begin
        pc_enable     = 1'b1;
        if_id_enable  = 1'b1;
        id_ex_enable  = 1'b1;
        ex_mem_enable = 1'b1;
        mem_wb_enable = 1'b1;
      end
    end

    mwb_prev_d = mem_wb_enable;

    // Bubbles and empty ID slots enter EX as a fully cleared NOP
    ex_d = ex_q;
    if (id_ex_enable) begin
      ex_d = '0;
      if (!id_ex_bubble && id_valid) begin
        ex_d.base.valid    = 1'b1;
        ex_d.base.rd       = id_rd;
        ex_d.base.rd_write = id_rd_write;
        ex_d.base.is_load  = id_is_load;
        ex_d.rs1           = id_rs1;
        ex_d.rs2           = id_rs2;
        ex_d.rs1_used      = id_rs1_used;
        ex_d.rs2_used      = id_rs2_used;
      end
    end
    mem_d = ex_mem_enable ? ex_q.base : mem_q;
    wb_d  = mem_wb_enable ? mem_q : wb_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q       <= '0;
      mem_q      <= '0;
      wb_q       <= '0;
      mwb_prev_q <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      ex_q       <= ex_d;
      mem_q      <= mem_d;
      wb_q       <= wb_d;
      mwb_prev_q <= mwb_prev_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  logic [REG_ADDR_W-1:0] op_rs   [2];
  logic                  op_used [2];
  fwd_sel_t              op_sel  [2];

  assign op_rs[0]   = ex_q.rs1;
  assign op_rs[1]   = ex_q.rs2;
  assign op_used[0] = ex_q.rs1_used;
  assign op_used[1] = ex_q.rs2_used;

  for (genvar i = 0; i < 2; i++) begin : g_fwd
    fwd_unit u_fwd (
      .rs      (op_rs[i]),
      .rs_used (op_used[i]),
      .mem_rec (mem_q),
      .wb_rec  (wb_q),
      .sel     (op_sel[i])
    );
  end

  assign fwd_a        = rst ? op_sel[0] : FWD_RF;
  assign fwd_b        = rst ? op_sel[1] : FWD_RF;
  assign wb_rd        = wb_q.rd;
  // Only the edge that actually moved an instruction into WB writes it
  assign wb_write     = rst & wb_q.valid & wb_q.rd_write & mwb_prev_q;
  assign stall_cycles = stall_q;
  assign flush_cycles = flush_q;

endmodule

`default_nettype wire

// File: doc/cpu_pipe_ctrl.md
# cpu_pipe_ctrl

Hazard and pipeline-sequencing controller for the five-stage (IF/ID/EX/MEM/WB) successor of the multi-cycle CPU core. It tracks the destination and load status of every in-flight instruction and drives all pipeline-register enables, bubbles and flushes. It also produces forwarding selects for both EX operands and counts stall and flush cycles. The controller sits beside the controller/regfile/ALU datapath and is the only source of pipeline enables.

## Interface
- DSize, 32, datapath width; sizes the cycle counters (min 16)
- RegAddrW, 5, register-address width (32 registers)
- CntW, 16, width of the stall and flush counters
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-low
- CPU_STALL  in  1  global freeze from system
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  RegAddrW  ID source registers
- id_rs1_used, id_rs2_used  in  1  source actually read
- id_rd  in  RegAddrW  ID destination
- id_rd_write  in  1  ID instruction writes rd
- id_is_load  in  1  ID instruction is a load
- ex_branch_taken  in  1  branch in EX resolved taken
- mem_wait  in  1  data memory not ready this cycle
- pc_enable, if_id_enable, id_ex_enable, ex_mem_enable, mem_wb_enable  out  1  stage-register enables
- if_id_flush, id_ex_bubble  out  1  clear IF/ID; load NOP into ID/EX
- fwd_a, fwd_b  out  2  EX operand source: 00 regfile, 01 EX/MEM, 10 MEM/WB
- wb_rd  out  RegAddrW, wb_write  out  1  regfile write address/enable
- stall_cycles, flush_cycles  out  CntW  saturating counters

## Operation
- Internal stage records ex/mem/wb: {valid, rd, rd_write, is_load}; EX record also holds rs1, rs2, rs1_used, rs2_used.
- Per-cycle action, highest priority first:
  - CPU_STALL=1: all enables 0, no flush/bubble, records hold.
  - mem_wait=1: same freeze. An EX branch waits; it is not lost.
  - ex_branch_taken=1 and ex.valid: pc_enable=1, if_id_flush=1, id_ex_bubble=1, remaining enables 1; flush_cycles+1.
  - Load-use: ex.valid & ex.is_load & ex.rd_write & id_valid & ((id_rs1_used & id_rs1==ex.rd) | (id_rs2_used & id_rs2==ex.rd)). pc_enable=0, if_id_enable=0, id_ex_bubble=1, ex_mem/mem_wb enables 1; stall_cycles+1.
  - Otherwise all enables 1.
- Frozen cycles (CPU_STALL or mem_wait) also increment stall_cycles.
- Record advance on an enabled edge: wb<=mem, mem<=ex, ex<=id inputs. A bubble loads ex with valid=0. id_valid=0 also loads ex.valid=0.
- Forwarding, combinational from records, per operand:
  - 01 if mem.valid & mem.rd_write & !mem.is_load & mem.rd==ex.rsN & ex.rsN_used;
  - else 10 if wb.valid & wb.rd_write & wb.rd==ex.rsN & ex.rsN_used;
  - else 00.
  - EX/MEM beats MEM/WB. All registers are forwardable, including r0.
- wb_write = wb.valid & wb.rd_write & mem_wb_enable_prev.
- Counters saturate at all-ones and never wrap.

## Timing
- Enables, flush, bubble and fwd are combinational, valid in the same cycle as their inputs. There is no combinational path from fwd to the enables.
- Load-use costs exactly 1 bubble. Taken branch costs exactly 2 squashed slots.
- Reset (rst=0 at an edge): all records valid=0, counters 0. Outputs during reset: all enables 0, flush 0, bubble 0, fwd 00, wb_write 0.
- Reset mid-stall or mid-branch discards all pending state; the first cycle after release has all enables 1.
- Simultaneous branch and load-use: branch wins and the ID instruction is squashed. No stall is counted; flush_cycles is counted.

## Structure
- Package cpu_pipe_pkg holds:
  - fwd_sel_t enum {FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10};
  - stage_rec_t packed struct;
  - RegAddrW default constant.
- Sub-module fwd_unit: purely combinational per-operand forwarding select, instantiated twice.
- The top holds the records, the priority logic and the counters.

## Test plan
- ADD r3 in EX, then SUB reading r3 in ID -> next cycle fwd_a=01, no stall, stall_cycles stays 0.
- LWI r5 in EX, ID reads r5 via rs2 -> 1 cycle with pc_enable=0, id_ex_bubble=1. Two cycles later fwd_b=10; stall_cycles=1.
- Taken branch in EX -> if_id_flush=1, id_ex_bubble=1, pc_enable=1 for 1 cycle; the two younger instructions never reach wb_write; flush_cycles=1.
- mem_wait held 3 cycles with a branch in EX -> all enables 0 for 3 cycles, then flush on cycle 4; stall_cycles=3, flush_cycles=1.
- Same rd in MEM and WB (r7) -> fwd selects 01. With a load in MEM -> selects 00 until the load reaches WB, then 10.
- rst=0 mid load-use stall -> records cleared and counters 0. After release all enables 1 and wb_write=0 for 3 cycles. Force stall_cycles to saturate at 16'hFFFF and confirm it holds.
